pc_gen: RTL and testbench

//  Next-PC generator and fetch-request source for the MCU front end. Holds the

---
 rtl/pc_gen_pkg.sv | 29 ++
 rtl/pc_gen_mux8.sv | 16 +
 rtl/pc_gen.sv | 153 +++++++++++++++
 tb/tb_pc_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared encodings for the next-PC generator.
// Used by pc_gen and by trace/hazard logic.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    PC_SEL_SEQ  = 3'd0,
    PC_SEL_HOLD = 3'd1,
    PC_SEL_BR   = 3'd2,
    PC_SEL_JAL  = 3'd3,
    PC_SEL_JALR = 3'd4,
    PC_SEL_TRAP = 3'd5,
    PC_SEL_MRET = 3'd6,
    PC_SEL_RST  = 3'd7
  } pc_sel_e;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WFI  = 2'd2
  } pc_state_e;

  // Selects 2..6 replace the fetch stream.
  function automatic logic is_redirect(
    input pc_sel_e s
  );
    return (s >= PC_SEL_BR) && (s <= PC_SEL_MRET);
  endfunction

endpackage

// File: rtl/pc_gen_mux8.sv
// Eight-way one-hot-free select mux.
// Feeds the next-PC register in pc_gen.
module mux8 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                 sel_i,
  input  logic [7:0][DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0]      q_o
);

  // Plain indexed select.
  always_comb begin
    q_o = d_i[sel_i];
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator and fetch-request source.
// Holds the fetch PC, arbitrates redirects, parks on WFI.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jal_i,
  input  logic [XLEN-1:0] jal_target_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            wfi_i,
  input  logic            wake_i,
  output logic            if_req_valid_o,
  input  logic            if_req_ready_i,
  output logic [XLEN-1:0] if_req_addr_o,
  output logic [2:0]      pc_sel_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  pc_state_e       state_q, state_d;
  pc_sel_e         sel;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic            accept;
  logic            jump_any;
  logic            jump_misal;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] mret_tgt;
  logic [XLEN-1:0] jump_tgt;
  logic [7:0][XLEN-1:0] mux_in;

  assign jalr_tgt = {jalr_target_i[XLEN-1:1], 1'b0};
  assign trap_tgt = {trap_vec_i[XLEN-1:2], 2'b00};
  assign mret_tgt = {mepc_i[XLEN-1:2], 2'b00};

  assign if_req_valid_o = rst_n
                        & (state_q == S_RUN)
                        & ~stall_i;
  assign accept = if_req_valid_o & if_req_ready_i;

  // Highest-priority jump target, checked for alignment.
  always_comb begin
    jump_tgt = br_target_i;
    if (jalr_i)     jump_tgt = jalr_tgt;
    else if (jal_i) jump_tgt = jal_target_i;
  end

  assign jump_any   = jalr_i | jal_i | br_taken_i;
  assign jump_misal = jump_any & (|jump_tgt[1:0]);

  // Priority encoder plus FSM next state and misalign capture.
  always_comb begin
    sel        = PC_SEL_HOLD;
    state_d    = state_q;
    misalign_d = 1'b0;
    mis_addr_d = mis_addr_q;
    if (!rst_n) begin
      sel = PC_SEL_RST;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          sel     = PC_SEL_RST;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (trap_i) begin
            sel = PC_SEL_TRAP;
          end else if (mret_i) begin
            sel = PC_SEL_MRET;
          end else if (jump_misal) begin
            misalign_d = 1'b1;
            mis_addr_d = jump_tgt;
          end else if (jalr_i) begin
            sel = PC_SEL_JALR;
          end else if (jal_i) begin
            sel = PC_SEL_JAL;
          end else if (br_taken_i) begin
            sel = PC_SEL_BR;
          end else if (wfi_i) begin
            state_d = S_WFI;
          end else if (accept) begin
            sel = PC_SEL_SEQ;
          end
        end
        S_WFI: begin
          if (trap_i) begin
            sel     = PC_SEL_TRAP;
            state_d = S_RUN;
          end else if (wake_i) begin
            state_d = S_RUN;
          end
        end
        default: begin
          sel     = PC_SEL_RST;
          state_d = S_BOOT;
        end
      endcase
    end
  end

  assign mux_in[PC_SEL_SEQ]  = pc_q + XLEN'(4);
  assign mux_in[PC_SEL_HOLD] = pc_q;
  assign mux_in[PC_SEL_BR]   = br_target_i;
  assign mux_in[PC_SEL_JAL]  = jal_target_i;
  assign mux_in[PC_SEL_JALR] = jalr_tgt;
  assign mux_in[PC_SEL_TRAP] = trap_tgt;
  assign mux_in[PC_SEL_MRET] = mret_tgt;
  assign mux_in[PC_SEL_RST]  = RESET_VECTOR;

  mux8 #(.DATA_WIDTH(XLEN)) u_next_pc_mux (
    .sel_i (sel),
    .d_i   (mux_in),
    .q_o   (pc_d)
  );

  // State, PC and misalign registers with sync reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign if_req_addr_o   = pc_q;
  assign pc_sel_o        = sel;
  assign flush_o         = is_redirect(sel);
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen.
// Fetch addresses are queued; a monitor checks each accept.
module tb_pc_gen;

  localparam int XLEN = 64;
  localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_i;
  logic            br_taken_i;
  logic [XLEN-1:0] br_target_i;
  logic            jal_i;
  logic [XLEN-1:0] jal_target_i;
  logic            jalr_i;
  logic [XLEN-1:0] jalr_target_i;
  logic            trap_i;
  logic [XLEN-1:0] trap_vec_i;
  logic            mret_i;
  logic [XLEN-1:0] mepc_i;
  logic            wfi_i;
  logic            wake_i;
  logic            if_req_valid_o;
  logic            if_req_ready_i;
  logic [XLEN-1:0] if_req_addr_o;
  logic [2:0]      pc_sel_o;
  logic            flush_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  pc_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .br_taken_i      (br_taken_i),
    .br_target_i     (br_target_i),
    .jal_i           (jal_i),
    .jal_target_i    (jal_target_i),
    .jalr_i          (jalr_i),
    .jalr_target_i   (jalr_target_i),
    .trap_i          (trap_i),
    .trap_vec_i      (trap_vec_i),
    .mret_i          (mret_i),
    .mepc_i          (mepc_i),
    .wfi_i           (wfi_i),
    .wake_i          (wake_i),
    .if_req_valid_o  (if_req_valid_o),
    .if_req_ready_i  (if_req_ready_i),
    .if_req_addr_o   (if_req_addr_o),
    .pc_sel_o        (pc_sel_o),
    .flush_o         (flush_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted fetch must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_req_valid_o === 1'b1
        && if_req_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fetch_unexpected: got %h want none",
                 if_req_addr_o);
      end else begin
        chk("fetch_addr", if_req_addr_o, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clr();
    stall_i    = 1'b0;
    br_taken_i = 1'b0;
    jal_i      = 1'b0;
    jalr_i     = 1'b0;
    trap_i     = 1'b0;
    mret_i     = 1'b0;
    wfi_i      = 1'b0;
    wake_i     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    if_req_ready_i = 1'b1;
    br_target_i    = '0;
    jal_target_i   = '0;
    jalr_target_i  = '0;
    trap_vec_i     = '0;
    mepc_i         = '0;
    clr();
    step();
    step();
    // reset state
    at_neg();
    chk("rst_valid", 64'(if_req_valid_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_sel", 64'(pc_sel_o), 64'd7);
    chk("rst_addr", if_req_addr_o, RV);
    chk("rst_mis", 64'(misalign_o), 64'd0);
    chk("rst_misaddr", misalign_addr_o, 64'd0);
    step();

    // 1: boot cycle, then sequential fetch
    rst_n = 1'b1;
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    exp_q.push_back(64'h8000_0008);
    exp_q.push_back(64'h8000_000C);
    at_neg();
    chk("boot_valid", 64'(if_req_valid_o), 64'd0);
    chk("boot_sel", 64'(pc_sel_o), 64'd7);
    step();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("seq_sel", 64'(pc_sel_o), 64'd0);
      step();
    end

    // 2: backpressure and stall
    if_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_valid", 64'(if_req_valid_o), 64'd1);
      chk("bp_addr", if_req_addr_o, 64'h8000_0010);
      chk("bp_sel", 64'(pc_sel_o), 64'd1);
      step();
    end
    if_req_ready_i = 1'b1;
    stall_i = 1'b1;
    at_neg();
    chk("stall_valid", 64'(if_req_valid_o), 64'd0);
    step();
    at_neg();
    chk("stall_addr", if_req_addr_o, 64'h8000_0010);
    stall_i = 1'b0;
    exp_q.push_back(64'h8000_0010);
    step();

    // 3: branch+jal, then trap on top
    if_req_ready_i = 1'b0;
    br_taken_i   = 1'b1;
    br_target_i  = 64'h8000_0100;
    jal_i        = 1'b1;
    jal_target_i = 64'h8000_0200;
    at_neg();
    chk("bj_flush", 64'(flush_o), 64'd1);
    chk("bj_sel", 64'(pc_sel_o), 64'd3);
    step();
    at_neg();
    chk("bj_addr", if_req_addr_o, 64'h8000_0200);
    trap_i     = 1'b1;
    trap_vec_i = 64'h8000_1003;
    at_neg();
    chk("trap_sel", 64'(pc_sel_o), 64'd5);
    chk("trap_flush", 64'(flush_o), 64'd1);
    step();
    clr();
    if_req_ready_i = 1'b1;
    exp_q.push_back(64'h8000_1000);
    step();

    // 4: misaligned jalr
    if_req_ready_i = 1'b0;
    jalr_i        = 1'b1;
    jalr_target_i = 64'h8000_0303;
    at_neg();
    chk("mis_flush", 64'(flush_o), 64'd0);
    chk("mis_sel", 64'(pc_sel_o), 64'd1);
    chk("mis_pre", 64'(misalign_o), 64'd0);
    step();
    clr();
    at_neg();
    chk("mis_pulse", 64'(misalign_o), 64'd1);
    chk("mis_addr", misalign_addr_o, 64'h8000_0302);
    chk("mis_pc", if_req_addr_o, 64'h8000_1004);
    step();
    at_neg();
    chk("mis_end", 64'(misalign_o), 64'd0);
    chk("mis_hold", misalign_addr_o, 64'h8000_0302);
    if_req_ready_i = 1'b1;
    exp_q.push_back(64'h8000_1004);
    step();

    // 5: wfi with wake, then wfi with trap
    if_req_ready_i = 1'b0;
    jal_i        = 1'b1;
    jal_target_i = 64'h8000_0040;
    step();
    clr();
    wfi_i = 1'b1;
    at_neg();
    chk("wfi_sel", 64'(pc_sel_o), 64'd1);
    step();
    clr();
    if_req_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("wfi_valid", 64'(if_req_valid_o), 64'd0);
      step();
    end
    mret_i = 1'b1;
    mepc_i = 64'h8000_0900;
    at_neg();
    chk("wfi_mret_ign", 64'(pc_sel_o), 64'd1);
    step();
    clr();
    wake_i = 1'b1;
    at_neg();
    chk("wake_valid", 64'(if_req_valid_o), 64'd0);
    step();
    clr();
    exp_q.push_back(64'h8000_0040);
    at_neg();
    chk("wake_valid2", 64'(if_req_valid_o), 64'd1);
    step();
    if_req_ready_i = 1'b0;
    wfi_i = 1'b1;
    step();
    clr();
    trap_i     = 1'b1;
    trap_vec_i = 64'h8000_1000;
    at_neg();
    chk("wtrap_sel", 64'(pc_sel_o), 64'd5);
    chk("wtrap_flush", 64'(flush_o), 64'd1);
    step();
    clr();
    if_req_ready_i = 1'b1;
    exp_q.push_back(64'h8000_1000);
    step();
    if_req_ready_i = 1'b0;
    trap_i     = 1'b1;
    wfi_i      = 1'b1;
    trap_vec_i = 64'h8000_2000;
    step();
    clr();
    if_req_ready_i = 1'b1;
    exp_q.push_back(64'h8000_2000);
    at_neg();
    chk("twfi_valid", 64'(if_req_valid_o), 64'd1);
    step();

    // 6: wrap, then reset during redirect
    if_req_ready_i = 1'b0;
    jal_i        = 1'b1;
    jal_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clr();
    if_req_ready_i = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    if_req_ready_i = 1'b0;
    at_neg();
    chk("wrap_addr", if_req_addr_o, 64'd0);
    mret_i = 1'b1;
    mepc_i = 64'h8000_0500;
    rst_n  = 1'b0;
    at_neg();
    chk("rr_flush", 64'(flush_o), 64'd0);
    chk("rr_sel", 64'(pc_sel_o), 64'd7);
    step();
    clr();
    rst_n = 1'b1;
    at_neg();
    chk("rr_addr", if_req_addr_o, RV);
    chk("rr_valid", 64'(if_req_valid_o), 64'd0);
    step();
    if_req_ready_i = 1'b1;
    exp_q.push_back(RV);
    step();
    if_req_ready_i = 1'b0;
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
